// File: rtl/viu_route_cfg_arbiter_pkg.sv
// Shared VIU types: route word layout, config FSM states
// and a small index-width helper.
package lynxTypes;

    localparam int VIU_ROUTE_BITS = 14;

    localparam int VIU_RT_SLOT_LSB     = 0;
    localparam int VIU_RT_SLOT_W       = 2;
    localparam int VIU_RT_VFPGA_LSB    = 2;
    localparam int VIU_RT_VFPGA_W      = 4;
    localparam int VIU_RT_NODE_LSB     = 6;
    localparam int VIU_RT_NODE_W       = 2;
    localparam int VIU_RT_SRC_VF_LSB   = 8;
    localparam int VIU_RT_SRC_VF_W     = 4;
    localparam int VIU_RT_SRC_NODE_LSB = 12;
    localparam int VIU_RT_SRC_NODE_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } viu_cfg_state_t;

    function automatic int viu_idx_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/viu_route_cfg_arbiter_rr_arb.sv
// Round-robin arbiter: first active request at or after
// the pointer wins; grant is one-hot, idle when disabled.
module viu_rr_arb #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_en,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx
);

    logic w_found;
    int   w_j;

    // Scan requesters starting at the pointer, wrapping once.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_j = (int'(i_ptr) + k) % N_REQ;
            if (i_en && !w_found && i_req[w_j]) begin
                o_grant[w_j] = 1'b1;
                o_idx        = IDX_W'(w_j);
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/viu_route_cfg_arbiter.sv
// Route-capability config arbiter for VIU RX gateways.
// Optional readback port: define VIU_CFG_READBACK_EN.
import lynxTypes::*;

module viu_route_cfg_arbiter #(
    parameter int N_REQ       = 2,
    parameter int N_GW        = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GW_BITS     = viu_idx_bits(N_GW),
    localparam int REQ_BITS   = viu_idx_bits(N_REQ)
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [N_REQ-1:0]                 req_valid,
    output logic [N_REQ-1:0]                 req_ready,
    input  logic [N_REQ*GW_BITS-1:0]         req_gw,
    input  logic [N_REQ*VIU_ROUTE_BITS-1:0]  req_ctrl,
    output logic [N_GW*VIU_ROUTE_BITS-1:0]   route_ctrl_o,
    output logic                             cpl_valid,
    output logic [REQ_BITS-1:0]              cpl_req,
    output logic [GW_BITS-1:0]               cpl_gw,
    output logic                             cpl_err,
    output logic                             busy
`ifdef VIU_CFG_READBACK_EN
    ,
    input  logic [GW_BITS-1:0]               rd_gw,
    output logic [VIU_ROUTE_BITS-1:0]        rd_ctrl
`endif
);

    localparam int CNT_W = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'(HOLD_CYCLES - 1);
    localparam logic [GW_BITS:0] GW_LIM =
        (GW_BITS + 1)'(N_GW);
    localparam logic [REQ_BITS-1:0] LAST_REQ =
        REQ_BITS'(N_REQ - 1);

    viu_cfg_state_t r_state;
    viu_cfg_state_t w_nxt;

    logic [REQ_BITS-1:0]       r_ptr;
    logic [REQ_BITS-1:0]       r_idx;
    logic [GW_BITS-1:0]        r_gw;
    logic                      r_err;
    logic [CNT_W-1:0]          r_cnt;
    logic [VIU_ROUTE_BITS-1:0] r_route [N_GW];

    logic [N_REQ-1:0]          w_grant;
    logic [REQ_BITS-1:0]       w_win;
    logic                      w_en;
    logic                      w_hs;
    logic                      w_in_rng;
    logic [GW_BITS-1:0]        w_sel_gw;
    logic [VIU_ROUTE_BITS-1:0] w_sel_ctrl;

    // Grants only while idle and out of reset.
    assign w_en = (r_state == IDLE) && aresetn;

    viu_rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (REQ_BITS)
    ) u_arb (
        .i_req   (req_valid),
        .i_en    (w_en),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win)
    );

    assign req_ready = w_grant;
    assign w_hs      = |(req_valid & w_grant);

    // Pick the winner's gateway index and route word.
    always_comb begin
        w_sel_gw   = req_gw[int'(w_win)*GW_BITS +: GW_BITS];
        w_sel_ctrl =
            req_ctrl[int'(w_win)*VIU_ROUTE_BITS +: VIU_ROUTE_BITS];
        w_in_rng   = ({1'b0, w_sel_gw} < GW_LIM);
    end

    // FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= IDLE;
        else          r_state <= w_nxt;
    end

    // Next state: bad gateway skips the hold phase.
    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_hs) w_nxt = w_in_rng ? DRIVE : DONE;
            DRIVE:   if (r_cnt == '0) w_nxt = DONE;
            DONE:    w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    // Latch the accepted request and run the hold counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ptr <= '0;
            r_idx <= '0;
            r_gw  <= '0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else if (w_hs) begin
            r_idx <= w_win;
            r_gw  <= w_sel_gw;
            r_err <= !w_in_rng;
            r_cnt <= CNT_LOAD;
            r_ptr <= (w_win == LAST_REQ) ? '0 : w_win + 1'b1;
        end else if (r_state == DRIVE && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Sticky per-gateway route words; only in-range writes land.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int g = 0; g < N_GW; g++) r_route[g] <= '0;
        end else if (w_hs && w_in_rng) begin
            for (int g = 0; g < N_GW; g++)
                if (w_sel_gw == GW_BITS'(g))
                    r_route[g] <= w_sel_ctrl;
        end
    end

    // Flatten route registers onto the gateway bus.
    always_comb begin
        route_ctrl_o = '0;
        for (int g = 0; g < N_GW; g++)
            route_ctrl_o[g*VIU_ROUTE_BITS +: VIU_ROUTE_BITS] =
                r_route[g];
    end

    assign busy      = (r_state != IDLE);
    assign cpl_valid = (r_state == DONE);
    assign cpl_req   = cpl_valid ? r_idx : '0;
    assign cpl_gw    = cpl_valid ? r_gw  : '0;
    assign cpl_err   = cpl_valid && r_err;

`ifdef VIU_CFG_READBACK_EN
    // Readback mux; out-of-range index reads zero.
    always_comb begin
        rd_ctrl = '0;
        for (int g = 0; g < N_GW; g++)
            if (rd_gw == GW_BITS'(g)) rd_ctrl = r_route[g];
    end
`endif

endmodule

// File: tb/tb_viu_route_cfg_arbiter.sv
// Scoreboard bench for viu_route_cfg_arbiter: reference model
// pushes expected completions, a monitor pops and compares.
module tb_viu_route_cfg_arbiter;

    localparam int NR = 3;
    localparam int NG = 3;
    localparam int HC = 4;
    localparam int GB = 2;
    localparam int RB = 2;
    localparam int RW = 14;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*GB-1:0] req_gw;
    logic [NR*RW-1:0] req_ctrl;
    logic [NG*RW-1:0] route_ctrl_o;
    logic             cpl_valid;
    logic [RB-1:0]    cpl_req;
    logic [GB-1:0]    cpl_gw;
    logic             cpl_err;
    logic             busy;
`ifdef VIU_CFG_READBACK_EN
    logic [GB-1:0]    rd_gw;
    logic [RW-1:0]    rd_ctrl;
`endif

    viu_route_cfg_arbiter #(
        .N_REQ(NR), .N_GW(NG), .HOLD_CYCLES(HC), .GW_BITS(GB)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_gw(req_gw), .req_ctrl(req_ctrl),
        .route_ctrl_o(route_ctrl_o),
        .cpl_valid(cpl_valid), .cpl_req(cpl_req),
        .cpl_gw(cpl_gw), .cpl_err(cpl_err), .busy(busy)
`ifdef VIU_CFG_READBACK_EN
        , .rd_gw(rd_gw), .rd_ctrl(rd_ctrl)
`endif
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event absent/unexpected (cycle %0d)",
                 nm, cyc);
    endtask

    typedef struct {
        int due;
        int rq;
        int gw;
        bit err;
    } exp_t;

    exp_t exq[$];

    // stimulus state
    logic          s_valid [NR];
    logic [GB-1:0] s_gw    [NR];
    logic [RW-1:0] s_ctrl  [NR];
    logic [NR-1:0] hs_prev = '0;

    task automatic apply();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]         = s_valid[i];
            req_gw[i*GB +: GB]   = s_gw[i];
            req_ctrl[i*RW +: RW] = s_ctrl[i];
        end
    endtask

    // reference model state
    int            m_rr   = 0;
    int            m_free = 0;
    logic [RW-1:0] m_route [NG];
    bit            m_pend = 0;
    int            m_pgw  = 0;
    logic [RW-1:0] m_pctl = '0;

    // Reference model: grant prediction, busy, route contents.
    initial begin
        for (int g = 0; g < NG; g++) m_route[g] = '0;
        forever begin
            logic [NR-1:0]    hs;
            logic [NR-1:0]    exp_rdy;
            logic [NG*RW-1:0] mflat;
            int               c;
            int               win;
            @(negedge aclk);
            #1;
            c   = cyc;
            hs  = '0;
            if (!aresetn) begin
                m_rr   = 0;
                m_free = c;
                m_pend = 0;
                for (int g = 0; g < NG; g++) m_route[g] = '0;
                check("reset_outputs_zero",
                      64'(|{req_ready, cpl_valid, cpl_req, cpl_gw,
                            cpl_err, busy, route_ctrl_o}), 64'd0);
            end else begin
                if (m_pend) begin
                    m_route[m_pgw] = m_pctl;
                    m_pend = 0;
                end
                for (int g = 0; g < NG; g++)
                    mflat[g*RW +: RW] = m_route[g];
                check("route_ctrl_o", 64'(route_ctrl_o), 64'(mflat));
                check("busy", 64'(busy), 64'(c < m_free));
                win = -1;
                if (c >= m_free) begin
                    for (int k = 0; k < NR; k++) begin
                        int j;
                        j = (m_rr + k) % NR;
                        if (win < 0 && req_valid[j]) win = j;
                    end
                end
                exp_rdy = '0;
                if (win >= 0) exp_rdy[win] = 1'b1;
                check("req_ready", 64'(req_ready), 64'(exp_rdy));
                if (win >= 0) begin
                    exp_t e;
                    int   g;
                    g     = int'(req_gw[win*GB +: GB]);
                    e.rq  = win;
                    e.gw  = g;
                    e.err = (g >= NG);
                    e.due = c + (e.err ? 1 : HC + 1);
                    exq.push_back(e);
                    if (!e.err) begin
                        m_pend = 1;
                        m_pgw  = g;
                        m_pctl = req_ctrl[win*RW +: RW];
                    end
                    m_free = c + (e.err ? 2 : HC + 2);
                    m_rr   = (win + 1) % NR;
                    hs[win] = 1'b1;
                end
            end
            hs_prev = hs;
        end
    end

    // Completion monitor: pop expected entry on each cpl pulse.
    initial begin
        forever begin
            @(negedge aclk);
            #1;
            if (!aresetn) begin
                exq.delete();
            end else if (cpl_valid) begin
                if (exq.size() == 0) begin
                    fail_now("cpl_unexpected");
                end else begin
                    exp_t e;
                    e = exq.pop_front();
                    check("cpl_cycle", 64'(cyc), 64'(e.due));
                    check("cpl_req", 64'(cpl_req), 64'(e.rq));
                    check("cpl_gw", 64'(cpl_gw), 64'(e.gw));
                    check("cpl_err", 64'(cpl_err), 64'(e.err));
                end
            end else if (exq.size() > 0 && exq[0].due < cyc) begin
                fail_now("cpl_missing");
                void'(exq.pop_front());
            end
        end
    end

    task automatic wait_hs(input int i, input string nm);
        bit got;
        got = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge aclk);
            if (hs_prev[i]) got = 1;
        end
        if (!got) fail_now(nm);
        s_valid[i] = 1'b0;
        apply();
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 40; n++) @(negedge aclk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_id;
        int last_c;
        int grants;
        aresetn = 1'b0;
        for (int i = 0; i < NR; i++) begin
            s_valid[i] = 1'b0;
            s_gw[i]    = '0;
            s_ctrl[i]  = '0;
        end
        apply();
`ifdef VIU_CFG_READBACK_EN
        rd_gw = '0;
`endif
        repeat (4) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        // basic write: req0 -> gw2
        s_valid[0] = 1'b1; s_gw[0] = 2'd2; s_ctrl[0] = 14'h1A5C;
        apply();
        wait_hs(0, "basic_grant_timeout");
        wait_idle();
        check("basic_gw2", 64'(route_ctrl_o[2*RW +: RW]),
              64'(14'h1A5C));

        // fairness: req0 and req1 continuously valid
        s_valid[0] = 1'b1; s_valid[1] = 1'b1;
        apply();
        last_id = -1;
        last_c  = 0;
        grants  = 0;
        for (int n = 0; n < 80 && grants < 8; n++) begin
            @(negedge aclk);
            for (int i = 0; i < 2; i++) begin
                if (hs_prev[i]) begin
                    if (last_id >= 0) begin
                        check("rr_alternate", 64'(i != last_id), 64'd1);
                        check("rr_spacing", 64'(cyc - last_c),
                              64'(HC + 2));
                    end
                    last_id = i;
                    last_c  = cyc;
                    grants++;
                    s_gw[i]   = 2'($urandom_range(NG - 1));
                    s_ctrl[i] = 14'($urandom);
                end
            end
            apply();
        end
        check("rr_grant_count", 64'(grants), 64'd8);
        s_valid[0] = 1'b0; s_valid[1] = 1'b0;
        apply();
        wait_idle();

        // range error: gw=3 with three gateways
        s_valid[2] = 1'b1; s_gw[2] = 2'd3; s_ctrl[2] = 14'h3FFF;
        apply();
        wait_hs(2, "range_grant_timeout");
        wait_idle();

        // sticky hold
        s_valid[1] = 1'b1; s_gw[1] = 2'd1; s_ctrl[1] = 14'h0304;
        apply();
        wait_hs(1, "sticky_grant_timeout");
        repeat (100) @(negedge aclk);
        check("sticky_gw1", 64'(route_ctrl_o[1*RW +: RW]),
              64'(14'h0304));

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            @(negedge aclk);
            for (int i = 0; i < NR; i++) begin
                if (hs_prev[i]) begin
                    s_valid[i] = 1'b0;
                end else if (s_valid[i]) begin
                    if ($urandom_range(9) == 0) s_valid[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    s_valid[i] = 1'b1;
                    s_gw[i]    = 2'($urandom_range(3));
                    s_ctrl[i]  = 14'($urandom);
                end
            end
            apply();
        end
        for (int i = 0; i < NR; i++) s_valid[i] = 1'b0;
        apply();
        wait_idle();

        // reset two cycles into the hold phase
        s_valid[1] = 1'b1; s_gw[1] = 2'd0; s_ctrl[1] = 14'h1234;
        apply();
        wait_hs(1, "rst_grant_timeout");
        @(negedge aclk);
        aresetn = 1'b0;
        s_valid[0] = 1'b1; s_gw[0] = 2'd1; s_ctrl[0] = 14'h0ABC;
        s_valid[1] = 1'b1; s_gw[1] = 2'd2; s_ctrl[1] = 14'h0DEF;
        apply();
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_reset_first_grant_req0", 64'(hs_prev), 64'b001);
        s_valid[0] = 1'b0;
        s_valid[1] = 1'b0;
        apply();
        wait_idle();

`ifdef VIU_CFG_READBACK_EN
        s_valid[0] = 1'b1; s_gw[0] = 2'd0; s_ctrl[0] = 14'h2F00;
        apply();
        wait_hs(0, "rd_grant_timeout");
        wait_idle();
        rd_gw = 2'd0;
        #1;
        check("readback_gw0", 64'(rd_ctrl), 64'(14'h2F00));
        rd_gw = 2'd3;
        #1;
        check("readback_oob", 64'(rd_ctrl), 64'd0);
`endif

        check("scoreboard_drained", 64'(exq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
